// File: rtl/dmem_arbiter_if.sv
// Bundle of requester A/B handshake signals and the single-port data memory bus
// shared between the arbiter (slave) and its environment (master).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              b_req;
  logic              a_we;
  logic              b_we;
  logic              a_lock;
  logic              b_lock;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] b_wdata;
  logic              a_gnt;
  logic              b_gnt;
  logic              a_rsp_valid;
  logic              b_rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_lock, b_lock,
    input  a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
    output a_gnt, b_gnt, a_rsp_valid, b_rsp_valid, rsp_rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_lock, b_lock,
    output a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
    input  a_gnt, b_gnt, a_rsp_valid, b_rsp_valid, rsp_rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with exclusive lock in front of a single-port
// synchronous data memory; responses follow grants by exactly one cycle.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           reset_x,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_gnt_q, last_gnt_d;  // 0 = A, 1 = B
  logic              a_rsp_valid_q, a_rsp_valid_d;
  logic              b_rsp_valid_q, b_rsp_valid_d;
  logic              a_gnt, b_gnt;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              mem_we_d;

  always_comb begin
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;

    // Grants are forced low while reset is held, independent of the async flops.
    if (!reset_x) begin
      unique case (state_q)
        IDLE: begin
          if (bus.a_req && bus.b_req) begin
            a_gnt = last_gnt_q;
            b_gnt = !last_gnt_q;
          end else begin
            a_gnt = bus.a_req;
            b_gnt = bus.b_req;
          end
        end
        LOCK_A:  a_gnt = bus.a_req;
        LOCK_B:  b_gnt = bus.b_req;
        default: state_d = IDLE;
      endcase
    end

    if (a_gnt) begin
      state_d     = bus.a_lock ? LOCK_A : IDLE;
      last_gnt_d  = 1'b0;
      mem_addr_d  = bus.a_addr;
      mem_wdata_d = bus.a_wdata;
      mem_we_d    = bus.a_we;
    end else if (b_gnt) begin
      state_d     = bus.b_lock ? LOCK_B : IDLE;
      last_gnt_d  = 1'b1;
      mem_addr_d  = bus.b_addr;
      mem_wdata_d = bus.b_wdata;
      mem_we_d    = bus.b_we;
    end

    a_rsp_valid_d = a_gnt;
    b_rsp_valid_d = b_gnt;
  end

  always_ff @(posedge clk or posedge reset_x) begin
    if (reset_x) begin
      state_q       <= IDLE;
      last_gnt_q    <= 1'b1;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
    end
  end

  assign bus.a_gnt       = a_gnt;
  assign bus.b_gnt       = b_gnt;
  assign bus.a_rsp_valid = a_rsp_valid_q;
  assign bus.b_rsp_valid = b_rsp_valid_q;
  assign bus.rsp_rdata   = bus.mem_rdata;
  assign bus.mem_addr    = mem_addr_d;
  assign bus.mem_wdata   = mem_wdata_d;
  assign bus.mem_we      = mem_we_d;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: synchronous memory model, response scoreboard and
// per-scenario grant checks.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_x = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_x (reset_x),
    .bus     (bus)
  );

  logic [DW-1:0] mem     [256] = '{16: 32'h55, 48: 32'h11, default: 32'h0};
  logic [DW-1:0] ref_mem [256] = '{16: 32'h55, 48: 32'h11, default: 32'h0};

  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  typedef struct {
    bit            port;  // 0 = A, 1 = B
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  bit exp_a, exp_b;

  // Scoreboard: every grant pushes the expected response, checked on the next cycle.
  always @(negedge clk) begin
    if (reset_x) begin
      sb.delete();
      tests++;
      if ({bus.a_gnt, bus.b_gnt, bus.a_rsp_valid, bus.b_rsp_valid, bus.mem_we} !== 5'b0) begin
        fails++;
        $display("FAIL reset_outputs: gnt/rsp/we=%b required 00000",
                 {bus.a_gnt, bus.b_gnt, bus.a_rsp_valid, bus.b_rsp_valid, bus.mem_we});
      end
    end else begin
      exp_a = (sb.size() > 0) && (sb[0].port == 1'b0);
      exp_b = (sb.size() > 0) && (sb[0].port == 1'b1);
      tests++;
      if ({bus.a_rsp_valid, bus.b_rsp_valid} !== {exp_a, exp_b}) begin
        fails++;
        $display("FAIL rsp_valid: got %b required %b",
                 {bus.a_rsp_valid, bus.b_rsp_valid}, {exp_a, exp_b});
      end
      if (sb.size() > 0) begin
        tests++;
        if (bus.rsp_rdata !== sb[0].data) begin
          fails++;
          $display("FAIL rsp_rdata: got %h required %h", bus.rsp_rdata, sb[0].data);
        end
        void'(sb.pop_front());
      end
      tests++;
      if ((bus.a_gnt & bus.b_gnt) !== 1'b0) begin
        fails++;
        $display("FAIL gnt_mutex: a_gnt=%b b_gnt=%b required not both", bus.a_gnt, bus.b_gnt);
      end
      if (bus.a_gnt === 1'b1) begin
        tests++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_we} !== {bus.a_addr, bus.a_wdata, bus.a_we}) begin
          fails++;
          $display("FAIL mem_bus_a: addr=%h wdata=%h we=%b required %h %h %b",
                   bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.a_addr, bus.a_wdata, bus.a_we);
        end
        sb.push_back('{port: 1'b0, data: ref_mem[bus.a_addr[7:0]]});
        if (bus.a_we) ref_mem[bus.a_addr[7:0]] = bus.a_wdata;
      end else if (bus.b_gnt === 1'b1) begin
        tests++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_we} !== {bus.b_addr, bus.b_wdata, bus.b_we}) begin
          fails++;
          $display("FAIL mem_bus_b: addr=%h wdata=%h we=%b required %h %h %b",
                   bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.b_addr, bus.b_wdata, bus.b_we);
        end
        sb.push_back('{port: 1'b1, data: ref_mem[bus.b_addr[7:0]]});
        if (bus.b_we) ref_mem[bus.b_addr[7:0]] = bus.b_wdata;
      end else begin
        tests++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_we} !== '0) begin
          fails++;
          $display("FAIL mem_bus_idle: addr=%h wdata=%h we=%b required all zero",
                   bus.mem_addr, bus.mem_wdata, bus.mem_we);
        end
      end
    end
  end

  task automatic drive_a(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.a_req = req; bus.a_we = we; bus.a_lock = lock; bus.a_addr = addr; bus.a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.b_req = req; bus.b_we = we; bus.b_lock = lock; bus.b_addr = addr; bus.b_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_a(1'b1, 1'b1, 1'b0, 32'h10, 32'h99);
    drive_b(1'b1, 1'b1, 1'b0, 32'h20, 32'h98);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.a_gnt, bus.b_gnt, bus.mem_we} !== 3'b000) begin
        fails++;
        $display("FAIL reset_gnt: gnt/we=%b required 000", {bus.a_gnt, bus.b_gnt, bus.mem_we});
      end
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    reset_x = 1'b0;
  endtask

  task automatic test_single_read();
    next_cycle();
    drive_a(1'b1, 1'b0, 1'b0, 32'h10, '0);
    @(negedge clk);
    tests++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      fails++;
      $display("FAIL single_read_gnt: got %b required 10", {bus.a_gnt, bus.b_gnt});
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests++;
    if (bus.a_rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h55) begin
      fails++;
      $display("FAIL single_read_rsp: valid=%b data=%h required 1 00000055",
               bus.a_rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_contention();
    next_cycle();
    reset_x = 1'b1;
    next_cycle();
    next_cycle();
    reset_x = 1'b0;
    drive_a(1'b1, 1'b0, 1'b0, 32'h40, '0);
    drive_b(1'b1, 1'b0, 1'b0, 32'h41, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.a_gnt, bus.b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL contention_gnt[%0d]: got %b required %b", i,
                 {bus.a_gnt, bus.b_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      next_cycle();
    end
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_lock();
    logic [2:0] lk;
    lk = 3'b110;
    next_cycle();
    drive_b(1'b1, 1'b1, 1'b1, 32'h20, 32'h7);
    @(negedge clk);
    tests++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL lock_first_gnt: got %b required 01", {bus.a_gnt, bus.b_gnt});
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive_a(1'b1, 1'b0, 1'b0, 32'h21, '0);
      drive_b(1'b1, 1'b0, lk[2-i], 32'h20, '0);
      @(negedge clk);
      tests++;
      if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
        fails++;
        $display("FAIL lock_hold_gnt[%0d]: got %b required 01", i, {bus.a_gnt, bus.b_gnt});
      end
    end
    next_cycle();
    drive_b(1'b1, 1'b0, 1'b0, 32'h22, '0);
    @(negedge clk);
    tests++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      fails++;
      $display("FAIL lock_release_gnt: got %b required 10", {bus.a_gnt, bus.b_gnt});
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_swap();
    next_cycle();
    drive_a(1'b1, 1'b1, 1'b0, 32'h30, 32'hAA);
    @(negedge clk);
    tests++;
    if ({bus.a_gnt, bus.mem_we} !== 2'b11) begin
      fails++;
      $display("FAIL swap_write: gnt/we=%b required 11", {bus.a_gnt, bus.mem_we});
    end
    next_cycle();
    drive_a(1'b1, 1'b0, 1'b0, 32'h30, '0);
    @(negedge clk);
    tests++;
    if (bus.a_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.rsp_rdata !== 32'h11) begin
      fails++;
      $display("FAIL swap_old_data: gnt=%b we=%b data=%h required 1 0 00000011",
               bus.a_gnt, bus.mem_we, bus.rsp_rdata);
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests++;
    if (bus.a_rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hAA) begin
      fails++;
      $display("FAIL swap_readback: valid=%b data=%h required 1 000000aa",
               bus.a_rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_lock_owner_idle();
    next_cycle();
    drive_a(1'b1, 1'b0, 1'b1, 32'h50, '0);
    @(negedge clk);
    tests++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      fails++;
      $display("FAIL owner_lock_gnt: got %b required 10", {bus.a_gnt, bus.b_gnt});
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b1, 1'b0, 1'b0, 32'h51, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.a_gnt, bus.b_gnt} !== 2'b00) begin
        fails++;
        $display("FAIL owner_idle_gnt[%0d]: got %b required 00", i, {bus.a_gnt, bus.b_gnt});
      end
      next_cycle();
    end
    drive_a(1'b1, 1'b0, 1'b0, 32'h50, '0);
    @(negedge clk);
    tests++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      fails++;
      $display("FAIL owner_unlock_gnt: got %b required 10", {bus.a_gnt, bus.b_gnt});
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL owner_after_gnt: got %b required 01", {bus.a_gnt, bus.b_gnt});
    end
    next_cycle();
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_midflight();
    next_cycle();
    drive_a(1'b1, 1'b0, 1'b0, 32'h10, '0);
    @(negedge clk);
    tests++;
    if (bus.a_gnt !== 1'b1) begin
      fails++;
      $display("FAIL midflight_gnt: got %b required 1", bus.a_gnt);
    end
    next_cycle();
    reset_x = 1'b1;
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    tests++;
    if (bus.a_rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL midflight_drop: a_rsp_valid=%b required 0", bus.a_rsp_valid);
    end
    next_cycle();
    next_cycle();
    reset_x = 1'b0;
    drive_a(1'b1, 1'b0, 1'b0, 32'h60, '0);
    drive_b(1'b1, 1'b0, 1'b0, 32'h61, '0);
    @(negedge clk);
    tests++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_rsp_valid, bus.b_rsp_valid} !== 4'b1000) begin
      fails++;
      $display("FAIL midflight_tie: gnt/rsp=%b required 1000",
               {bus.a_gnt, bus.b_gnt, bus.a_rsp_valid, bus.b_rsp_valid});
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      @(negedge clk);
      tests++;
      if ({bus.a_gnt, bus.b_gnt, bus.a_rsp_valid, bus.b_rsp_valid, bus.mem_we} !== 5'b0) begin
        fails++;
        $display("FAIL idle[%0d]: gnt/rsp/we=%b required 00000", i,
                 {bus.a_gnt, bus.b_gnt, bus.a_rsp_valid, bus.b_rsp_valid, bus.mem_we});
      end
    end
    next_cycle();
    drive_a(1'b1, 1'b0, 1'b0, 32'h70, '0);
    drive_b(1'b1, 1'b0, 1'b0, 32'h71, '0);
    @(negedge clk);
    tests++;
    if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL idle_state_kept: got %b required 01", {bus.a_gnt, bus.b_gnt});
    end
    next_cycle();
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_a(1'b0, 1'b0, 1'b0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_single_read();
    test_contention();
    test_lock();
    test_swap();
    test_lock_owner_idle();
    test_reset_midflight();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
